timer_responder: RTL and testbench

- Memory-mapped countdown timer device that answers the data-side bus driven by the M pipeline stage.
- The stage's memory write enable, byte lanes and address/data are decoded by the bridge and delivered here.
- Provides CTRL/PRESET/COUNT registers and a level or pulse interrupt toward CP0.
- Sits beside data memory behind the bridge; the bridge selects it by address hit.

---
 rtl/timer_responder_if.sv | 21 ++
 rtl/timer_responder.sv | 120 ++++++++++++
 tb/tb_timer_responder.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/timer_responder_if.sv
// Data-side bus between the memory bridge and the timer device.
// Carries the decoded M-stage write/read signals plus the interrupt line.
interface timer_responder_if;
    logic [31:0] addr;
    logic        we;
    logic [3:0]  byte_en;
    logic [31:0] wdata;
    logic        hit;
    logic [31:0] rdata;
    logic        irq;

    modport master (
        output addr, we, byte_en, wdata,
        input  hit, rdata, irq
    );

    modport slave (
        input  addr, we, byte_en, wdata,
        output hit, rdata, irq
    );
endinterface

// File: rtl/timer_responder.sv
// Memory-mapped countdown timer: CTRL/PRESET/COUNT registers, a 4-state
// countdown FSM and a one-shot (level) or auto-reload (pulse) interrupt.
module timer_responder #(
    parameter logic [31:0] BASE     = 32'h0000_7F00,
    parameter logic        IM_RESET = 1'b0
) (
    input logic             clk,
    input logic             reset,
    timer_responder_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_CNT  = 2'd2,
        ST_INT  = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  ctrl_q, ctrl_d;      // [3]=IM, [2:1]=MODE, [0]=EN
    logic [31:0] preset_q, preset_d;
    logic [31:0] count_q, count_d;
    logic        irq_flag_q, irq_flag_d;

    logic [1:0]  sel;
    logic        wr;
    logic        wr_ctrl;
    logic        wr_preset;
    logic        unused_addr;

    assign sel         = bus.addr[3:2];
    assign bus.hit     = (bus.addr[31:4] == BASE[31:4]);
    assign wr          = bus.we & bus.hit;
    assign wr_ctrl     = wr && (sel == 2'd0);
    assign wr_preset   = wr && (sel == 2'd1);
    assign bus.irq     = ctrl_q[3] & irq_flag_q;
    assign unused_addr = ^bus.addr[1:0];

    // Read mux on the word offset; unused CTRL bits and offset 0xC read zero.
    always_comb begin
        bus.rdata = '0;
        case (sel)
            2'd0:    bus.rdata = {28'd0, ctrl_q};
            2'd1:    bus.rdata = preset_q;
            2'd2:    bus.rdata = count_q;
            default: bus.rdata = '0;
        endcase
    end

    // FSM next-state, counter update and register writes.
    // Bus writes are applied after the FSM so they override its EN clear and
    // irq_flag set when both land on the same edge.
    always_comb begin
        state_d    = state_q;
        ctrl_d     = ctrl_q;
        preset_d   = preset_q;
        count_d    = count_q;
        irq_flag_d = irq_flag_q;

        case (state_q)
            ST_IDLE: begin
                if (ctrl_q[0]) state_d = ST_LOAD;
            end
            ST_LOAD: begin
                count_d = preset_q;
                state_d = ST_CNT;
            end
            ST_CNT: begin
                if (!ctrl_q[0]) begin
                    state_d = ST_IDLE;
                end else if (count_q > 32'd1) begin
                    count_d = count_q - 32'd1;
                end else begin
                    count_d    = '0;
                    irq_flag_d = 1'b1;
                    state_d    = ST_INT;
                end
            end
            ST_INT: begin
                if (ctrl_q[2:1] == 2'b01) begin
                    irq_flag_d = 1'b0;
                end else begin
                    ctrl_d[0] = 1'b0;
                end
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        if (wr_ctrl && bus.byte_en[0]) begin
            ctrl_d = bus.wdata[3:0];
        end
        if (wr_preset) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (bus.byte_en[i]) preset_d[8*i +: 8] = bus.wdata[8*i +: 8];
            end
        end
        if (wr_ctrl || wr_preset) begin
            irq_flag_d = 1'b0;
        end
    end

    // State and register storage with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            ctrl_q     <= {IM_RESET, 3'b000};
            preset_q   <= '0;
            count_q    <= '0;
            irq_flag_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ctrl_q     <= ctrl_d;
            preset_q   <= preset_d;
            count_q    <= count_d;
            irq_flag_q <= irq_flag_d;
        end
    end

endmodule

// File: tb/tb_timer_responder.sv
// Directed bench for timer_responder: reset, one-shot, auto-reload,
// byte lanes, address decode, write/FSM collisions and async reset.
module tb_timer_responder;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    timer_responder_if bus ();

    timer_responder #(
        .BASE     (32'h0000_7F00),
        .IM_RESET (1'b0)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        bus.addr    = a;
        bus.wdata   = d;
        bus.byte_en = be;
        bus.we      = 1'b1;
        tick();
        bus.we      = 1'b0;
    endtask

    task automatic rd(input string tag, input logic [31:0] a, input logic [31:0] exp);
        bus.addr = a;
        #1;
        check(tag, bus.rdata, exp);
    endtask

    task automatic chk_irq(input string tag, input logic exp);
        check(tag, {31'd0, bus.irq}, {31'd0, exp});
    endtask

    initial begin
        checks      = 0;
        errors      = 0;
        reset       = 1'b0;
        bus.addr    = 32'h0000_7F00;
        bus.we      = 1'b0;
        bus.byte_en = 4'h0;
        bus.wdata   = '0;

        // Reset held: a CTRL write must not land
        tick();
        wr(32'h7F00, 32'h9, 4'hF);
        tick();
        reset = 1'b1;
        tick();
        rd("rst_ctrl", 32'h7F00, 32'h0);
        rd("rst_preset", 32'h7F04, 32'h0);
        rd("rst_count", 32'h7F08, 32'h0);
        chk_irq("rst_irq", 1'b0);

        // One-shot: PRESET=5, CTRL=IM|EN
        wr(32'h7F04, 32'd5, 4'hF);
        wr(32'h7F00, 32'h9, 4'hF);
        tick();                                   // LOAD
        tick();                                   // CNT, COUNT=5
        rd("os_count5", 32'h7F08, 32'd5);
        chk_irq("os_irq_low", 1'b0);
        for (int i = 4; i >= 0; i--) begin
            tick();
            rd($sformatf("os_count%0d", i), 32'h7F08, i);
        end
        chk_irq("os_irq_rise", 1'b1);
        tick();                                   // INT -> IDLE, EN cleared
        rd("os_ctrl_en_clr", 32'h7F00, 32'h8);
        chk_irq("os_irq_hold", 1'b1);
        tick();
        chk_irq("os_irq_hold2", 1'b1);
        rd("os_count_idle", 32'h7F08, 32'd0);
        wr(32'h7F04, 32'd3, 4'hF);
        chk_irq("os_irq_clr", 1'b0);

        // Auto-reload: PRESET=2, CTRL=IM|MODE01|EN; irq at k=4,9,14
        wr(32'h7F04, 32'd2, 4'hF);
        wr(32'h7F00, 32'hB, 4'hF);
        for (int k = 1; k <= 14; k++) begin
            tick();
            chk_irq($sformatf("ar_irq_k%0d", k), (k % 5) == 4);
        end
        tick();
        tick();
        tick();                                   // CNT, COUNT=2
        rd("ar_count2", 32'h7F08, 32'd2);
        wr(32'h7F00, 32'h0, 4'hF);                // decrement still happens on this edge
        rd("ar_count1", 32'h7F08, 32'd1);
        for (int k = 0; k < 6; k++) begin
            tick();
            rd("ar_frozen", 32'h7F08, 32'd1);
            chk_irq("ar_no_pulse", 1'b0);
        end

        // Byte lanes and read-only COUNT
        wr(32'h7F04, 32'h1122_3344, 4'hF);
        wr(32'h7F04, 32'hAABB_CCDD, 4'b0010);
        rd("lane_preset", 32'h7F04, 32'h1122_CC44);
        wr(32'h7F08, 32'h0000_FFFF, 4'hF);
        rd("count_ro", 32'h7F08, 32'd1);

        // Address decode
        bus.addr = 32'h7F10;
        #1;
        check("miss_hit", {31'd0, bus.hit}, 32'd0);
        wr(32'h7F10, 32'hFFFF_FFFF, 4'hF);
        wr(32'h7F14, 32'hFFFF_FFFF, 4'hF);
        rd("miss_ctrl", 32'h7F00, 32'h0);
        rd("miss_preset", 32'h7F04, 32'h1122_CC44);
        wr(32'h7F0C, 32'hFFFF_FFFF, 4'hF);
        check("off_c_hit", {31'd0, bus.hit}, 32'd1);
        rd("off_c_rdata", 32'h7F0C, 32'h0);
        rd("off_c_preset", 32'h7F04, 32'h1122_CC44);

        // CTRL write landing on the one-shot INT edge
        wr(32'h7F04, 32'd2, 4'hF);
        wr(32'h7F00, 32'h9, 4'hF);
        tick();                                   // LOAD
        tick();                                   // CNT 2
        tick();                                   // CNT 1
        tick();                                   // INT
        chk_irq("col_int_irq", 1'b1);
        wr(32'h7F00, 32'h9, 4'hF);                // commits on INT edge
        rd("col_ctrl_wins", 32'h7F00, 32'h9);
        chk_irq("col_irq_clr", 1'b0);
        tick();                                   // LOAD
        tick();                                   // CNT 2
        rd("col_reload", 32'h7F08, 32'd2);
        tick();                                   // CNT 1
        // PRESET write on the CNT->INT edge: clear beats set, COUNT unaffected
        wr(32'h7F04, 32'd7, 4'hF);
        chk_irq("col2_irq", 1'b0);
        rd("col2_count", 32'h7F08, 32'd0);
        tick();                                   // INT -> IDLE
        rd("col2_ctrl", 32'h7F00, 32'h8);
        chk_irq("col2_irq_idle", 1'b0);

        // Asynchronous reset mid-count
        wr(32'h7F04, 32'd5, 4'hF);
        wr(32'h7F00, 32'h9, 4'hF);
        tick();
        tick();
        tick();
        tick();
        rd("ar_pre_count3", 32'h7F08, 32'd3);
        #1;
        reset = 1'b0;
        #1;
        rd("arst_count", 32'h7F08, 32'd0);
        rd("arst_ctrl", 32'h7F00, 32'h0);
        rd("arst_preset", 32'h7F04, 32'h0);
        chk_irq("arst_irq", 1'b0);
        tick();
        reset = 1'b1;
        tick();
        tick();
        rd("arst_idle_count", 32'h7F08, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
